uart_rx_deser: RTL and testbench

- Receive-side serial front end for the UART peripheral: synchronizes the raw RX pin, finds start bits, and deserializes 8N1/8E1/8O1 frames with 16x oversampling.
- Sits between the pad (cio_rx) and the RX FIFO / interrupt logic of the UART core.
- Produces one single-cycle valid strobe per received character, with frame, parity and break status.
- The baud-rate x16 enable tick is generated outside this block by the core's NCO.

---
 rtl/uart_rx_deser.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// uart_rx_deser
//   Receive-side serial front end of the UART. Synchronizes the raw RX pin,
//   detects start bits and deserializes 8N1 / 8E1 / 8O1 frames using a
//   16x oversampling tick supplied by the core's NCO.
//
// Ports
//   clk_i          block clock
//   rst_i          synchronous active-high reset
//   rx_enable_i    receiver enable; low forces IDLE and drops any frame in flight
//   tick_x16_i     one-cycle enable at 16x the baud rate
//   parity_en_i    a parity bit follows the data bits
//   parity_odd_i   1 = odd parity, 0 = even parity
//   rx_i           raw asynchronous RX line, idle high
//   rx_data_o      received character (LSB first on the line)
//   rx_valid_o     one-cycle strobe qualifying rx_data_o and the flags
//   frame_err_o    stop bit sampled low
//   parity_err_o   parity mismatch
//   break_o        break detected (all-zero frame with low stop bit)
//   idle_o         high while the FSM is in IDLE
module uart_rx_deser #(
   parameter int SyncStages = 2,
   parameter int MidSample  = 7
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_enable_i,
   input  logic       tick_x16_i,
   input  logic       parity_en_i,
   input  logic       parity_odd_i,
   input  logic       rx_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       frame_err_o,
   output logic       parity_err_o,
   output logic       break_o,
   output logic       idle_o
);

   localparam logic [3:0] MID_TICK = 4'(MidSample);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
   } state_t;

   state_t                state_reg, state_next;
   logic [SyncStages-1:0] sync_reg;
   logic                  rx_s;
   logic [3:0]            tick_cnt_reg, tick_cnt_next;
   logic [2:0]            bit_cnt_reg, bit_cnt_next;
   logic [7:0]            shift_reg, shift_next;
   logic                  par_en_reg, par_en_next;
   logic                  par_odd_reg, par_odd_next;
   logic                  par_bit_reg, par_bit_next;
   logic [7:0]            data_reg, data_next;
   logic                  valid_reg, valid_next;
   logic                  frame_reg, frame_next;
   logic                  parity_reg, parity_next;
   logic                  break_reg, break_next;

   // Input synchronizer; resets to the idle (high) line level so that
   // leaving reset never looks like a start bit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_reg <= '1;
      end else begin
         sync_reg <= {sync_reg[SyncStages-2:0], rx_i};
      end
   end
   assign rx_s = sync_reg[SyncStages-1];

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tick_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         par_en_reg   <= 1'b0;
         par_odd_reg  <= 1'b0;
         par_bit_reg  <= 1'b0;
         data_reg     <= '0;
         valid_reg    <= 1'b0;
         frame_reg    <= 1'b0;
         parity_reg   <= 1'b0;
         break_reg    <= 1'b0;
      end else begin
         tick_cnt_reg <= tick_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         par_en_reg   <= par_en_next;
         par_odd_reg  <= par_odd_next;
         par_bit_reg  <= par_bit_next;
         data_reg     <= data_next;
         valid_reg    <= valid_next;
         frame_reg    <= frame_next;
         parity_reg   <= parity_next;
         break_reg    <= break_next;
      end
   end

   // Next-state and datapath logic
   always_comb begin
      state_next    = state_reg;
      tick_cnt_next = tick_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      par_en_next   = par_en_reg;
      par_odd_next  = par_odd_reg;
      par_bit_next  = par_bit_reg;
      data_next     = data_reg;
      valid_next    = 1'b0;
      frame_next    = frame_reg;
      parity_next   = parity_reg;
      break_next    = break_reg;

      if (!rx_enable_i) begin
         // Disable overrides everything, including a stop-bit strobe.
         state_next    = IDLE;
         tick_cnt_next = '0;
         bit_cnt_next  = '0;
      end else if (tick_x16_i) begin
         tick_cnt_next = tick_cnt_reg + 4'd1;   // wraps 15 -> 0
         case (state_reg)
            IDLE: begin
               tick_cnt_next = '0;
               if (!rx_s) begin
                  state_next = START;
               end
            end
            START: begin
               if (tick_cnt_reg == MID_TICK) begin
                  // Line back high at mid-start means a glitch, not a frame.
                  tick_cnt_next = '0;
                  bit_cnt_next  = '0;
                  state_next    = rx_s ? IDLE : DATA;
               end
            end
            DATA: begin
               if (tick_cnt_reg == 4'd15) begin
                  shift_next[bit_cnt_reg] = rx_s;
                  bit_cnt_next            = bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     // Parity configuration is frozen here for the frame.
                     par_en_next  = parity_en_i;
                     par_odd_next = parity_odd_i;
                     state_next   = parity_en_i ? PARITY : STOP;
                  end
               end
            end
            PARITY: begin
               if (tick_cnt_reg == 4'd15) begin
                  par_bit_next = rx_s;
                  state_next   = STOP;
               end
            end
            STOP: begin
               if (tick_cnt_reg == 4'd15) begin
                  valid_next  = 1'b1;
                  data_next   = shift_reg;
                  frame_next  = !rx_s;
                  parity_next = par_en_reg &&
                                ((^shift_reg ^ par_bit_reg) != par_odd_reg);
                  break_next  = !rx_s && (shift_reg == 8'h00) &&
                                (!par_en_reg || !par_bit_reg);
                  // A low stop bit parks the FSM until the line recovers so
                  // a long break yields a single character.
                  state_next  = rx_s ? IDLE : WAIT_HIGH;
               end
            end
            WAIT_HIGH: begin
               tick_cnt_next = '0;
               if (rx_s) begin
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign rx_data_o    = data_reg;
   assign rx_valid_o   = valid_reg;
   assign frame_err_o  = frame_reg;
   assign parity_err_o = parity_reg;
   assign break_o      = break_reg;
   assign idle_o       = (state_reg == IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
module tb_uart_rx_deser;

   localparam int BIT_CLKS = 64;   // 16 ticks x 4 clocks

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       rx_enable_i = 1'b1;
   logic       tick_x16_i = 1'b0;
   logic       parity_en_i = 1'b0;
   logic       parity_odd_i = 1'b0;
   logic       rx_i = 1'b1;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       frame_err_o;
   logic       parity_err_o;
   logic       break_o;
   logic       idle_o;

   typedef struct {
      logic [7:0] data;
      logic       fe;
      logic       pe;
      logic       brk;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   tick_div = 0;

   uart_rx_deser dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rx_enable_i  (rx_enable_i),
      .tick_x16_i   (tick_x16_i),
      .parity_en_i  (parity_en_i),
      .parity_odd_i (parity_odd_i),
      .rx_i         (rx_i),
      .rx_data_o    (rx_data_o),
      .rx_valid_o   (rx_valid_o),
      .frame_err_o  (frame_err_o),
      .parity_err_o (parity_err_o),
      .break_o      (break_o),
      .idle_o       (idle_o)
   );

   always #5 clk_i = ~clk_i;

   // x16 tick every 4 clocks, changed on the falling edge
   always @(negedge clk_i) begin
      tick_div   = (tick_div + 1) % 4;
      tick_x16_i = (tick_div == 0);
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every strobe must match the oldest expectation
   always @(negedge clk_i) begin
      if (rx_valid_o === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_strobe", {7'd0, rx_valid_o}, 8'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("strobe data=%02h fe=%0b pe=%0b brk=%0b (want %02h %0b %0b %0b)",
                     rx_data_o, frame_err_o, parity_err_o, break_o, e.data, e.fe, e.pe, e.brk);
            check("data", rx_data_o, e.data);
            check("frame_err", {7'd0, frame_err_o}, {7'd0, e.fe});
            check("parity_err", {7'd0, parity_err_o}, {7'd0, e.pe});
            check("break", {7'd0, break_o}, {7'd0, e.brk});
         end
      end
   end

   task automatic drive_bit(input logic b, input int clks);
      rx_i = b;
      repeat (clks) @(negedge clk_i);
   endtask

   // Sends one frame and pushes the expected result first.
   task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                             input logic podd, input logic stop);
      exp_t e;
      e.data = d;
      e.fe   = !stop;
      e.pe   = pen && ((^d ^ pbit) != podd);
      e.brk  = !stop && (d == 8'h00) && (!pen || !pbit);
      sb.push_back(e);
      parity_en_i  = pen;
      parity_odd_i = podd;
      drive_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
      if (pen) drive_bit(pbit, BIT_CLKS);
      drive_bit(stop, BIT_CLKS);
      drive_bit(1'b1, 2 * BIT_CLKS);
   endtask

   task automatic check_reset_outputs(input string tag);
      $display("reset check (%s)", tag);
      check({tag, "_data"}, rx_data_o, 8'h00);
      check({tag, "_valid"}, {7'd0, rx_valid_o}, 8'd0);
      check({tag, "_fe"}, {7'd0, frame_err_o}, 8'd0);
      check({tag, "_pe"}, {7'd0, parity_err_o}, 8'd0);
      check({tag, "_brk"}, {7'd0, break_o}, 8'd0);
      check({tag, "_idle"}, {7'd0, idle_o}, 8'd1);
   endtask

   initial begin
      logic [7:0] d;
      repeat (4) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      check_reset_outputs("rst");

      // 8N1 0xA5
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
      check("idle_after_a5", {7'd0, idle_o}, 8'd1);

      // 8E1 0x3C with parity bit 0: even -> ok, odd -> error
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
      parity_en_i  = 1'b0;
      parity_odd_i = 1'b0;

      // 5-tick low glitch: false start, no strobe
      $display("glitch");
      drive_bit(1'b0, 20);
      drive_bit(1'b1, 4 * BIT_CLKS);
      check("idle_after_glitch", {7'd0, idle_o}, 8'd1);

      // Break: 30 bit times low, one strobe, parked in WAIT_HIGH
      $display("break");
      begin
         exp_t e;
         e.data = 8'h00; e.fe = 1'b1; e.pe = 1'b0; e.brk = 1'b1;
         sb.push_back(e);
      end
      drive_bit(1'b0, 30 * BIT_CLKS);
      check("wait_high_not_idle", {7'd0, idle_o}, 8'd0);
      check("break_pending", 8'(sb.size()), 8'd0);
      drive_bit(1'b1, 2 * BIT_CLKS);
      check("idle_after_break", {7'd0, idle_o}, 8'd1);

      // 0x55 with a low stop bit
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset pulse in the middle of bit 4 of 0xF0 (bits 4..7 and stop high)
      $display("reset mid-frame");
      d = 8'hF0;
      drive_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) drive_bit(d[i], BIT_CLKS);
      rx_i = 1'b1;
      repeat (32) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      check_reset_outputs("midrst");
      drive_bit(1'b1, 5 * BIT_CLKS);
      check("idle_after_midrst", {7'd0, idle_o}, 8'd1);

      // Clean frame afterwards
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);

      repeat (20) @(negedge clk_i);
      check("scoreboard_empty", 8'(sb.size()), 8'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
